// File: rtl/test_src_pkg.sv
// Shared types and LFSR helpers for the stream source and its companion
// random-timing blocks.
package test_src_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SEND,
    DONE
  } state_t;

  // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/test_src_lfsr.sv
// 16-bit Galois LFSR with enable; reloads its seed during reset.
module test_src_lfsr
  import test_src_pkg::*;
#(
  parameter logic [15:0] p_seed = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  output logic [15:0] o_state
);

  // An all-zero seed would lock the register, so it falls back to the default
  localparam logic [15:0] c_seed = (p_seed == 16'h0000) ? LFSR_DEFAULT_SEED : p_seed;

  logic [15:0] r_state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_seed;
    end else if (i_en) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/test_stream_source.sv
// Val/rdy message source: replays a preloaded table with seeded random
// inter-message gaps and flags done after the final handshake.
module test_stream_source
  import test_src_pkg::*;
#(
  parameter int          p_msg_nbits = 8,
  parameter int          p_num_msgs  = 16,
  parameter int          p_max_delay = 3,
  parameter logic [15:0] p_seed      = 16'hACE1,
  localparam int         c_aw        = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1,
  localparam int         c_cw        = $clog2(p_num_msgs + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [c_aw-1:0]        load_addr,
  input  logic [p_msg_nbits-1:0] load_data,
  input  logic                   start,
  input  logic [c_cw-1:0]        num_msgs,
  output logic                   msg_val,
  input  logic                   msg_rdy,
  output logic [p_msg_nbits-1:0] msg,
  output logic                   done,
  output logic [c_cw-1:0]        sent_count
);

  localparam int              c_dw       = (p_max_delay > 0) ? $clog2(p_max_delay + 1) : 1;
  localparam logic [c_dw-1:0] c_dly_mask = c_dw'(p_max_delay);
  localparam logic [15:0]     c_mask16   = 16'(p_max_delay);
  localparam logic [c_cw-1:0] c_num_max  = c_cw'(p_num_msgs);

  state_t                 r_state, w_state_next;
  logic [c_cw-1:0]        r_total, w_total_next;
  logic [c_cw-1:0]        r_idx, w_idx_next;
  logic [c_cw-1:0]        r_sent, w_sent_next;
  logic [c_dw-1:0]        r_cnt, w_cnt_next;
  logic                   r_val, w_val_next;
  logic                   r_done, w_done_next;
  logic [p_msg_nbits-1:0] r_msg;
  logic [p_msg_nbits-1:0] r_table [p_num_msgs];

  logic [15:0]            w_lfsr;
  logic                   w_lfsr_en;
  logic [c_dw-1:0]        w_gap;
  logic                   w_gap_zero;
  logic [c_cw-1:0]        w_clamped;
  logic                   w_wr_en;
  logic                   w_fire;
  logic [p_msg_nbits-1:0] w_rd_data;

  test_src_lfsr #(
    .p_seed (p_seed)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_lfsr_en),
    .o_state (w_lfsr)
  );

  assign w_gap      = w_lfsr[c_dw-1:0] & c_dly_mask;
  assign w_gap_zero = ((w_lfsr & c_mask16) == 16'h0000);
  assign w_clamped  = (num_msgs > c_num_max) ? c_num_max : num_msgs;
  assign w_wr_en    = load_en && ((r_state == IDLE) || (r_state == DONE));
  assign w_fire     = r_val && msg_rdy;

  always_comb begin
    w_state_next = r_state;
    w_total_next = r_total;
    w_idx_next   = r_idx;
    w_sent_next  = r_sent;
    w_cnt_next   = r_cnt;
    w_val_next   = r_val;
    w_done_next  = r_done;
    w_lfsr_en    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_total_next = w_clamped;
          w_idx_next   = '0;
          w_sent_next  = '0;
          w_done_next  = 1'b0;
          w_val_next   = 1'b0;
          if (w_clamped == '0) begin
            w_state_next = DONE;
            w_done_next  = 1'b1;
          end else begin
            w_lfsr_en = 1'b1;
            if (w_gap_zero) begin
              w_state_next = SEND;
              w_val_next   = 1'b1;
            end else begin
              w_state_next = DELAY;
              w_cnt_next   = w_gap;
            end
          end
        end
      end
      DELAY: begin
        w_val_next = 1'b0;
        if (r_cnt == c_dw'(1)) begin
          w_state_next = SEND;
          w_val_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt - c_dw'(1);
        end
      end
      SEND: begin
        if (w_fire) begin
          w_idx_next  = r_idx + c_cw'(1);
          w_sent_next = r_sent + c_cw'(1);
          if (r_idx + c_cw'(1) == r_total) begin
            w_state_next = DONE;
            w_done_next  = 1'b1;
            w_val_next   = 1'b0;
          end else begin
            // Gaps are drawn only on handshakes, so stalls never perturb the sequence
            w_lfsr_en = 1'b1;
            if (!w_gap_zero) begin
              w_state_next = DELAY;
              w_cnt_next   = w_gap;
              w_val_next   = 1'b0;
            end
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_val_next   = 1'b0;
      end
    endcase
  end

  // Write-first: a same-edge load at the address being fetched is forwarded
  assign w_rd_data = (w_wr_en && (load_addr == w_idx_next[c_aw-1:0])) ?
                     load_data : r_table[w_idx_next[c_aw-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_table[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_total <= '0;
      r_idx   <= '0;
      r_sent  <= '0;
      r_cnt   <= '0;
      r_val   <= 1'b0;
      r_done  <= 1'b0;
      r_msg   <= '0;
    end else begin
      r_state <= w_state_next;
      r_total <= w_total_next;
      r_idx   <= w_idx_next;
      r_sent  <= w_sent_next;
      r_cnt   <= w_cnt_next;
      r_val   <= w_val_next;
      r_done  <= w_done_next;
      r_msg   <= w_val_next ? w_rd_data : '0;
    end
  end

  assign msg_val    = r_val;
  assign msg        = r_msg;
  assign done       = r_done;
  assign sent_count = r_sent;

endmodule

// File: tb/tb_test_stream_source.sv
// Directed bench: dut0 runs back-to-back (no gaps), dut1 uses seeded gaps.
module tb_test_stream_source;

  logic       clk = 1'b0;
  logic       reset, load_en, start, msg_rdy;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [4:0] num_msgs;

  logic       val0, done0, val1, done1;
  logic [7:0] msg0, msg1;
  logic [4:0] sent0, sent1;

  int tests  = 0;
  int failed = 0;

  logic [7:0]  tb_table [16];
  logic [15:0] model_lfsr;
  logic        bp_rdy  [7];
  logic [7:0]  bp_msg  [7];
  int          bp_sent [7];
  int          fires;

  always #5 clk = ~clk;

  test_stream_source #(
    .p_msg_nbits (8), .p_num_msgs (16), .p_max_delay (0), .p_seed (16'hACE1)
  ) dut0 (
    .clk (clk), .reset (reset), .load_en (load_en), .load_addr (load_addr),
    .load_data (load_data), .start (start), .num_msgs (num_msgs),
    .msg_val (val0), .msg_rdy (msg_rdy), .msg (msg0), .done (done0),
    .sent_count (sent0)
  );

  test_stream_source #(
    .p_msg_nbits (8), .p_num_msgs (16), .p_max_delay (3), .p_seed (16'h0001)
  ) dut1 (
    .clk (clk), .reset (reset), .load_en (load_en), .load_addr (load_addr),
    .load_data (load_data), .start (start), .num_msgs (num_msgs),
    .msg_val (val1), .msg_rdy (msg_rdy), .msg (msg1), .done (done1),
    .sent_count (sent1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Drives one start on dut1 and checks every cycle against the LFSR gap model
  task automatic run_random(input int n, input string tag);
    int g;
    start    = 1'b1;
    num_msgs = n[4:0];
    msg_rdy  = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_done_clr"}, done1, 0);
    for (int m = 0; m < n; m++) begin
      g = int'(model_lfsr[1:0]);
      model_lfsr = model_next(model_lfsr);
      for (int j = 0; j < g; j++) begin
        check({tag, "_gap_val"}, val1, 0);
        step();
      end
      check({tag, "_msg_val"}, val1, 1);
      check({tag, "_msg"}, msg1, tb_table[m]);
      step();
    end
    check({tag, "_done"}, done1, 1);
    check({tag, "_val_end"}, val1, 0);
    check({tag, "_sent"}, sent1, n);
    $display("[TB] %s: %0d messages checked against gap model", tag, n);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) tb_table[i] = 8'hA0 + 8'(i);
    tb_table[0] = 8'h11; tb_table[1] = 8'h22; tb_table[2] = 8'h33; tb_table[3] = 8'h44;

    // Reset held with start asserted
    reset = 1'b0; load_en = 1'b0; start = 1'b1; num_msgs = 5'd4; msg_rdy = 1'b1;
    load_addr = '0; load_data = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_val0", val0, 0);
      check("rst_val1", val1, 0);
      check("rst_done0", done0, 0);
      check("rst_sent0", sent0, 0);
      check("rst_msg0", msg0, 0);
    end
    $display("[TB] reset held 3 cycles");

    // Load entries 1..15; entry 0 is written on the start edge itself
    reset = 1'b1; start = 1'b0;
    for (int i = 1; i < 16; i++) begin
      load_en = 1'b1; load_addr = 4'(i); load_data = tb_table[i];
      step();
    end
    load_addr = 4'd0; load_data = tb_table[0]; start = 1'b1; num_msgs = 5'd4;
    step();
    load_en = 1'b0; start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("b2b_val", val0, 1);
      check("b2b_msg", msg0, tb_table[k]);
      check("b2b_sent", sent0, k);
      step();
    end
    check("b2b_done", done0, 1);
    check("b2b_val_end", val0, 0);
    check("b2b_msg_end", msg0, 0);
    check("b2b_sent_end", sent0, 4);
    $display("[TB] back-to-back 4 messages");

    // Backpressure, restarting from DONE
    bp_rdy[0] = 1; bp_rdy[1] = 0; bp_rdy[2] = 0; bp_rdy[3] = 0;
    bp_rdy[4] = 1; bp_rdy[5] = 1; bp_rdy[6] = 1;
    bp_msg[0] = 8'h11; bp_msg[1] = 8'h22; bp_msg[2] = 8'h22; bp_msg[3] = 8'h22;
    bp_msg[4] = 8'h22; bp_msg[5] = 8'h33; bp_msg[6] = 8'h44;
    bp_sent[0] = 0; bp_sent[1] = 1; bp_sent[2] = 1; bp_sent[3] = 1;
    bp_sent[4] = 1; bp_sent[5] = 2; bp_sent[6] = 3;
    start = 1'b1; num_msgs = 5'd4;
    step();
    start = 1'b0;
    check("bp_done_clr", done0, 0);
    for (int k = 0; k < 7; k++) begin
      check("bp_val", val0, 1);
      check("bp_msg", msg0, bp_msg[k]);
      check("bp_sent", sent0, bp_sent[k]);
      msg_rdy = bp_rdy[k];
      step();
    end
    check("bp_done", done0, 1);
    check("bp_sent_end", sent0, 4);
    check("bp_val_end", val0, 0);
    $display("[TB] backpressure run");

    // Zero-length request
    start = 1'b1; num_msgs = 5'd0;
    step();
    start = 1'b0;
    check("n0_done", done0, 1);
    check("n0_sent", sent0, 0);
    for (int k = 0; k < 3; k++) begin
      check("n0_val", val0, 0);
      step();
    end
    $display("[TB] num_msgs=0");

    // Oversized request clamps to the table depth
    start = 1'b1; num_msgs = 5'd20; msg_rdy = 1'b1;
    step();
    start = 1'b0;
    fires = 0;
    for (int c = 0; c < 20; c++) begin
      if (val0) begin
        check("n20_msg", msg0, tb_table[fires]);
        fires++;
      end
      step();
    end
    check("n20_fires", fires, 16);
    check("n20_sent", sent0, 16);
    check("n20_done", done0, 1);
    $display("[TB] num_msgs=20 clamped");

    // Abort mid-SEND with reset
    start = 1'b1; num_msgs = 5'd4; msg_rdy = 1'b0;
    step();
    start = 1'b0;
    check("abort_val_pre", val0, 1);
    check("abort_msg_pre", msg0, 8'h11);
    reset = 1'b0;
    step();
    check("abort_val", val0, 0);
    check("abort_msg", msg0, 0);
    check("abort_sent", sent0, 0);
    check("abort_done", done0, 0);
    reset = 1'b1; msg_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_idle_val", val0, 0);
      check("abort_idle_done", done0, 0);
    end
    $display("[TB] reset abort");

    // Seeded gaps: two runs from reset must match, then a continued run
    reset = 1'b0;
    step();
    reset = 1'b1;
    model_lfsr = 16'h0001;
    run_random(8, "rnd1");
    reset = 1'b0;
    step();
    reset = 1'b1;
    model_lfsr = 16'h0001;
    run_random(8, "rnd2");
    run_random(8, "rnd3");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/test_stream_source.md
Name: test_stream_source

Overview:
- Synthesizable val/rdy message source for queue benches; the producing end of the result-check flow.
- A per-clock checker compares and scores values; this block generates the message streams that feed the DUT.
- The bench preloads a message table, pulses start, and the block drives messages with seeded pseudo-random inter-message gaps.
- Asserts done when the last message handshakes.

Parameters:
- p_msg_nbits, 8, message width.
- p_num_msgs, 16, message table depth (>=1).
- p_max_delay, 3, max random gap in cycles; must be 2^k-1 (0 = back-to-back).
- p_seed, 16'hACE1, LFSR reset value; 0 is remapped to 16'hACE1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- load_en  in  1  write message table entry
- load_addr  in  $clog2(p_num_msgs)  table index
- load_data  in  p_msg_nbits  table data
- start  in  1  begin sending (one-cycle pulse)
- num_msgs  in  $clog2(p_num_msgs+1)  messages to send, sampled at start
- msg_val  out  1  message valid
- msg_rdy  in  1  consumer ready
- msg  out  p_msg_nbits  message payload
- done  out  1  all requested messages sent
- sent_count  out  $clog2(p_num_msgs+1)  handshakes completed

Behaviour:
- All state updates occur on posedge clk.
- reset==0 at an edge forces: state=IDLE, msg_val=0, msg=0, done=0, sent_count=0, lfsr=p_seed (or 16'hACE1 if p_seed==0).
- Table contents are not reset. Reset mid-send aborts with no further handshakes.
- States:
  - IDLE: load_en writes table[load_addr]<=load_data. On start: latch total=min(num_msgs,p_num_msgs), sent_count<=0, idx<=0.
    - total==0 -> DONE.
    - Otherwise take gap=lfsr&p_max_delay and advance the LFSR: gap==0 -> SEND, else DELAY with cnt=gap.
  - DELAY: msg_val=0. cnt decrements each cycle; when cnt==1 -> SEND. Gap g gives exactly g idle cycles.
  - SEND: msg_val=1, msg=table[idx]. msg and msg_val stay stable until msg_rdy. Fire = msg_val&&msg_rdy. On fire: idx++, sent_count++.
    - idx+1==total -> DONE.
    - Otherwise draw a new gap: 0 -> stay SEND with the next message (1 msg/cycle), else -> DELAY.
  - DONE: done=1, msg_val=0. load_en is permitted. start restarts exactly as from IDLE and clears done on the same edge.
- msg is a registered output: table read addressed by next idx. msg=0 whenever msg_val=0.
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances only when a gap is drawn (start or fire), so the gap sequence is seed-deterministic regardless of backpressure.
- load_en while in DELAY/SEND is ignored.
- start while in DELAY/SEND is ignored.
- load_en and start on the same edge in IDLE: the write completes and sending starts. A message at the loaded index is read after the write (write-first).
- num_msgs > p_num_msgs clamps to p_num_msgs.
- msg_rdy is don't-care when msg_val=0.

Decomposition:
- Shared package test_src_pkg:
  - state enum {IDLE, DELAY, SEND, DONE}
  - LFSR tap constant and default seed
  - lfsr_next function
- One sub-module, test_src_lfsr (16-bit, enable, seed load on reset), reusable by a future random-backpressure sink.
- Table is a local register array.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 -> msg_val=0, done=0, sent_count=0 throughout; no handshake.
- Back-to-back: p_max_delay=0, load table[0..3]=8'h11,22,33,44, num_msgs=4, msg_rdy=1 -> msg 11,22,33,44 on 4 consecutive cycles starting the cycle after start; done=1 the cycle after the 4th fire; sent_count=4.
- Backpressure: p_max_delay=0, same table, msg_rdy low for cycles 2-4 after start -> msg holds 8'h22 with msg_val=1 until rdy returns; order unchanged; no duplicate or drop.
- Random gaps: p_max_delay=3, p_seed=16'h0001, 8 messages, msg_rdy=1 -> idle gaps match a reference model of the LFSR; a second run with the same seed reproduces the identical cycle trace.
- Boundaries:
  - num_msgs=0 -> done next cycle, msg_val never asserted.
  - num_msgs=20 with p_num_msgs=16 -> exactly 16 sent.
- Restart/abort:
  - start in DONE resends the table from index 0.
  - reset=0 mid-SEND -> msg_val=0 next cycle; after release, stays IDLE until start.
